relu_maxpool2x2: RTL
====================

Name: relu_maxpool2x2

Overview:
- Downstream of the convolution MAC stage. Consumes the saturated signed 8-bit convolution results as a raster-ordered feature-map stream.
- Applies an optional ReLU to each sample, then 2x2 max-pooling with stride 2.
- Emits one pooled sample per 2x2 window to the next layer's input buffer. Uses a half-width line buffer; no backpressure.

Parameters:
- DATA_W, 8, sample width; two's complement signed.
- IMG_W, 28, input feature-map width in samples; must be even and at least 2.
- IMG_H, 28, input feature-map height in rows; must be even and at least 2.
- RELU_EN, 1, 1 = clamp negative inputs to 0 before pooling; 0 = pool raw signed values.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous frame restart; zeroes the row/column counters.
- in_valid  input  1  in_data is a valid sample this cycle; may be asserted every cycle or have gaps.
- in_data  input  DATA_W  signed convolution result; raster order, row-major.
- out_valid  output  1  one-cycle strobe; out_data holds a pooled sample.
- out_data  output  DATA_W  signed pooled sample.
- out_last  output  1  asserted with out_valid on the final pooled sample of the frame.

Behaviour:
- Reset: out_valid=0, out_data=0, out_last=0, col=0, row=0, hold register=0. Line-buffer contents are not reset; every entry is written before it is read.
- clear: same effect as reset on the counters and the hold register. If clear and in_valid are both high, clear wins and the sample is discarded. The next accepted sample is pixel (0,0).
- Counters advance only on accepted samples:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1, widths $clog2(IMG_W) and $clog2(IMG_H).
  - When col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1) both counters wrap to 0. The next frame follows with no idle cycle required.
- ReLU: x = (RELU_EN && in_data<0) ? 0 : in_data. All comparisons are signed.
- Even col: hold <= x.
- Odd col: hmax = max(hold, x).
  - Even row: linebuf[col>>1] <= hmax.
  - Odd row: pooled = max(linebuf[col>>1], hmax).
- Line-buffer read timing:
  - The read of linebuf[col>>1] is issued on the accepted even-col sample of an odd row. The read data register holds its value until the next read, so input gaps are tolerated.
- Output timing:
  - On an accepted odd-col sample of an odd row, out_valid=1 and out_data=pooled on the next cycle, i.e. latency 1 cycle from the bottom-right window sample.
  - out_last=1 in that same cycle when the sample was at (IMG_H-1, IMG_W-1).
  - Otherwise out_valid=0 and out_last=0. out_data holds its last value.
- Throughput: one input per cycle sustained. Output rate is IMG_W/2 pulses per odd row, none on even rows. Total IMG_W*IMG_H/4 outputs per frame.
- No arithmetic widening; max selects one operand, so -128 and 127 pass through unchanged.
- Reset mid-frame: the partial window is dropped and no output is produced for it.

Decomposition:
- Shared package nn_pkg:
  - localparam DATA_W=8;
  - signed sample typedef sample_t;
  - function smax(a,b) for the signed max.
- One sub-module, pool_line_buf: simple dual-port RAM, depth IMG_W/2, width DATA_W, synchronous write, registered read with read enable.
- The top module holds the counters, hold register, comparators and output registers.

Test Plan:
- 4x4 frame, input 0..15 raster, RELU_EN=1 -> out_data 5,7,13,15; out_last only with 15; each strobe 1 cycle after inputs 5,7,13,15 respectively.
- 4x4 frame, all -5 except pixel (1,1)=-128, RELU_EN=0 -> four outputs of -5. Repeat with RELU_EN=1 -> four outputs of 0.
- 2x2 frame with values -128,127,0,-1 and random in_valid gaps of 0-3 cycles -> single output 127 with out_last=1, latency 1 after the final sample.
- Back-to-back 4x4 frames with no idle cycle, second frame all 127 -> 8 outputs total; second frame's four all 127; out_last on outputs 4 and 8.
- clear asserted after 6 samples of a 4x4 frame, coincident with in_valid=1 -> that sample discarded; a fresh ramp frame yields 5,7,13,15.
- reset held 1 cycle mid-row-1, then a full 4x4 ramp -> all outputs 0 immediately after reset, then exactly 5,7,13,15.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-network datapath blocks.
// sample_t is the signed activation word passed between layers; smax picks
// the larger of two samples without widening, so the extremes pass unchanged.
package nn_pkg;

    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Signed maximum: returns one of the operands, never a computed value.
    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer for the 2x2 pooler.
// Simple dual-port RAM: synchronous write, registered read with read enable.
// The read register holds its value until the next enabled read so the
// consumer may stall between the read and the use of the data.
// Contents are not reset; the pooler writes every entry before reading it.
module pool_line_buf #(
    parameter int DEPTH  = 14,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    // Write port: store the horizontal max of an even-row pair.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, updated only when a read is issued.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/relu_maxpool2x2.sv
// Optional ReLU followed by 2x2 / stride-2 max pooling on a raster stream.
// Even rows: each horizontal pair max is parked in the line buffer.
// Odd rows: the stored pair max for the same column pair is read back when
// the even-column sample arrives and combined with the current pair max when
// the odd-column sample arrives, producing one pooled sample one cycle later.
// DATA_W must equal nn_pkg::DATA_W since the comparators use sample_t.
module relu_maxpool2x2 #(
    parameter int DATA_W  = 8,
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last
);

    import nn_pkg::*;

    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DEPTH  = IMG_W / 2;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;
    sample_t          hold_reg, hold_next;
    logic             out_valid_reg, out_valid_next;
    sample_t          out_data_reg, out_data_next;
    logic             out_last_reg, out_last_next;

    logic              accept;
    logic              col_odd;
    logic              row_odd;
    sample_t           x;
    sample_t           hmax;
    sample_t           pooled;
    logic [ADDR_W-1:0] lb_addr;
    logic              lb_wr_en;
    logic              lb_rd_en;
    logic [DATA_W-1:0] lb_rd_data;

    // clear has priority over a coincident sample, which is dropped.
    assign accept  = in_valid && !clear;
    assign col_odd = col_reg[0];
    assign row_odd = row_reg[0];

    // Both columns of a pair share one line-buffer slot.
    assign lb_addr  = ADDR_W'(col_reg >> 1);
    assign lb_wr_en = accept && col_odd && !row_odd;
    assign lb_rd_en = accept && !col_odd && row_odd;

    pool_line_buf #(
        .DEPTH  (DEPTH),
        .WIDTH  (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (lb_addr),
        .wr_data (hmax),
        .rd_en   (lb_rd_en),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_data)
    );

    // ReLU, horizontal pair max and final 2x2 max.
    always_comb begin
        x = in_data;
        if (RELU_EN && in_data[DATA_W-1]) begin
            x = '0;
        end
        hmax   = smax(hold_reg, x);
        pooled = smax(sample_t'(lb_rd_data), hmax);
    end

    // Next-state: raster counters, hold register and output registers.
    always_comb begin
        col_next       = col_reg;
        row_next       = row_reg;
        hold_next      = hold_reg;
        out_valid_next = 1'b0;
        out_last_next  = 1'b0;
        out_data_next  = out_data_reg;

        if (clear) begin
            col_next  = '0;
            row_next  = '0;
            hold_next = '0;
        end else if (accept) begin
            if (!col_odd) begin
                hold_next = x;
            end
            if (col_odd && row_odd) begin
                out_valid_next = 1'b1;
                out_data_next  = pooled;
                out_last_next  = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
            end
            if (col_reg == COL_LAST) begin
                col_next = '0;
                row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    // State register with synchronous reset; a partial window is simply lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_reg       <= '0;
            row_reg       <= '0;
            hold_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            col_reg       <= col_next;
            row_reg       <= row_next;
            hold_reg      <= hold_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;

endmodule
